xs3_stuck0_monitor: RTL and testbench

Downstream consumer of the BCD-to-Excess-3 stage. It accepts Excess-3 digits under a valid/ready handshake and decodes each one back to BCD with one cycle of latency, flagging any illegal codes. Over a window of WINDOW accepted digits it records which code bits were ever 1, then reports a per-bit stuck-at-0 mask. It closes the loop for the stuck-at-0 detector: BCD source → Excess-3 encoder → this monitor.

---
 rtl/xs3_stuck0_monitor.sv | 135 +++++++++++++
 tb/tb_xs3_stuck0_monitor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/xs3_stuck0_monitor.sv
// Excess-3 digit monitor: decodes accepted digits back to BCD, counts illegal codes
// and reports which code bits never went high over a window of accepted digits.
module xs3_stuck0_monitor #(
  parameter int WINDOW = 10,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       xs3_in,
  output logic             bcd_valid,
  output logic [3:0]       bcd_out,
  output logic             code_err,
  output logic [CNT_W-1:0] err_count,
  output logic             done,
  output logic [3:0]       stuck_mask
);

  localparam int DW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       seen_q, seen_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             code_err_q, code_err_d;
  logic             done_q, done_d;
  logic [3:0]       mask_q, mask_d;
  logic             accept_s;

  function automatic logic xs3_illegal(input logic [3:0] code);
    return (code < 4'd3) || (code > 4'd12);
  endfunction

  assign accept_s = in_valid && (state_q == S_ACCUM);

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    bcd_valid_d = 1'b0;
    bcd_d       = bcd_q;
    code_err_d  = code_err_q;
    done_d      = 1'b0;
    mask_d      = mask_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          seen_d  = 4'b0000;
          cnt_d   = '0;
          err_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (accept_s) begin
          seen_d      = seen_q | xs3_in;
          cnt_d       = cnt_q + DW'(1);
          bcd_valid_d = 1'b1;
          if (xs3_illegal(xs3_in)) begin
            bcd_d      = 4'd0;
            code_err_d = 1'b1;
            if (err_q != {CNT_W{1'b1}}) begin
              err_d = err_q + CNT_W'(1);
            end else begin
              err_d = err_q;
            end
          end else begin
            bcd_d      = xs3_in - 4'd3;
            code_err_d = 1'b0;
          end
          // The final digit's bits must be folded into the reported mask
          if (cnt_q == DW'(WINDOW - 1)) begin
            state_d = S_REPORT;
            done_d  = 1'b1;
            mask_d  = ~(seen_q | xs3_in);
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seen_q      <= 4'b0000;
      cnt_q       <= '0;
      err_q       <= '0;
      bcd_valid_q <= 1'b0;
      bcd_q       <= 4'd0;
      code_err_q  <= 1'b0;
      done_q      <= 1'b0;
      mask_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      bcd_valid_q <= bcd_valid_d;
      bcd_q       <= bcd_d;
      code_err_q  <= code_err_d;
      done_q      <= done_d;
      mask_q      <= mask_d;
    end
  end

  assign in_ready   = (state_q == S_ACCUM);
  assign bcd_valid  = bcd_valid_q;
  assign bcd_out    = bcd_q;
  assign code_err   = code_err_q;
  assign err_count  = err_q;
  assign done       = done_q;
  assign stuck_mask = mask_q;

endmodule

// File: tb/tb_xs3_stuck0_monitor.sv
// Directed self-checking bench for xs3_stuck0_monitor (WINDOW = 10, CNT_W = 2).
module tb_xs3_stuck0_monitor;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] xs3_in;
  logic       bcd_valid;
  logic [3:0] bcd_out;
  logic       code_err;
  logic [1:0] err_count;
  logic       done;
  logic [3:0] stuck_mask;

  int checks = 0;
  int errors = 0;
  logic [3:0] vec [10];

  xs3_stuck0_monitor #(.WINDOW(10), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xs3_in    (xs3_in),
    .bcd_valid (bcd_valid),
    .bcd_out   (bcd_out),
    .code_err  (code_err),
    .err_count (err_count),
    .done      (done),
    .stuck_mask(stuck_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full window of vec[]; gaps inserts idle cycles and pokes start/in_valid during REPORT
  task automatic run_window(input string name, input bit gaps, input logic [3:0] exp_mask);
    int  exp_err;
    bit  ill;
    exp_err = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({name, "_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      xs3_in   = vec[i];
      tick();
      in_valid = 1'b0;
      ill = (vec[i] < 4'd3) || (vec[i] > 4'd12);
      if (ill && exp_err < 3) exp_err++;
      check_eq({name, "_bvalid"}, 32'(bcd_valid), 32'd1);
      check_eq({name, "_bcd"}, 32'(bcd_out), ill ? 32'd0 : 32'(vec[i]) - 32'd3);
      check_eq({name, "_cerr"}, 32'(code_err), 32'(ill));
      check_eq({name, "_errcnt"}, 32'(err_count), 32'(exp_err));
      check_eq({name, "_done"}, 32'(done), 32'(i == 9));
      if (i == 9) begin
        check_eq({name, "_mask"}, 32'(stuck_mask), 32'(exp_mask));
        check_eq({name, "_ready_rep"}, 32'(in_ready), 32'd0);
      end else if (gaps) begin
        tick();
        check_eq({name, "_gap_bvalid"}, 32'(bcd_valid), 32'd0);
        check_eq({name, "_gap_done"}, 32'(done), 32'd0);
        check_eq({name, "_gap_ready"}, 32'(in_ready), 32'd1);
      end
    end
    if (gaps) begin
      start    = 1'b1;
      in_valid = 1'b1;
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check_eq({name, "_post_done"}, 32'(done), 32'd0);
    check_eq({name, "_post_ready"}, 32'(in_ready), 32'd0);
    check_eq({name, "_post_bvalid"}, 32'(bcd_valid), 32'd0);
    check_eq({name, "_post_errcnt"}, 32'(err_count), 32'(exp_err));
    tick();
    check_eq({name, "_idle_ready"}, 32'(in_ready), 32'd0);
    check_eq({name, "_idle_mask"}, 32'(stuck_mask), 32'(exp_mask));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; xs3_in = 4'd0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      xs3_in   = 4'($urandom_range(0, 15));
      tick();
    end
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_bvalid", 32'(bcd_valid), 32'd0);
    check_eq("rst_bcd", 32'(bcd_out), 32'd0);
    check_eq("rst_cerr", 32'(code_err), 32'd0);
    check_eq("rst_errcnt", 32'(err_count), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_mask", 32'(stuck_mask), 32'd0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();
    check_eq("rst_idle_ready", 32'(in_ready), 32'd0);

    // Clean sweep 0011..1100
    for (int i = 0; i < 10; i++) vec[i] = 4'(i + 3);
    run_window("sweep", 1'b0, 4'b0000);

    // Ten 0011 digits leave bits 3 and 2 unseen
    for (int i = 0; i < 10; i++) vec[i] = 4'b0011;
    run_window("stuck", 1'b0, 4'b1100);

    // Reset mid-window after four illegal accepts
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("mid_mask_held", 32'(stuck_mask), 32'hC);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; xs3_in = 4'b0000;
      tick();
    end
    in_valid = 1'b0;
    check_eq("mid_errcnt_sat", 32'(err_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
    check_eq("mid_rst_errcnt", 32'(err_count), 32'd0);
    check_eq("mid_rst_mask", 32'(stuck_mask), 32'd0);
    check_eq("mid_rst_bvalid", 32'(bcd_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; xs3_in = 4'd5;
      tick();
      check_eq("mid_nostart_bvalid", 32'(bcd_valid), 32'd0);
      check_eq("mid_nostart_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) vec[i] = 4'(i + 3);
    run_window("resweep", 1'b0, 4'b0000);

    // Illegal codes with CNT_W = 2 saturation
    vec[0] = 4'b0000; vec[1] = 4'b1111; vec[2] = 4'b0001; vec[3] = 4'b1101; vec[4] = 4'b0010;
    for (int i = 5; i < 10; i++) vec[i] = 4'b0101;
    run_window("illegal", 1'b0, 4'b0000);

    // Handshake gaps, in_valid in IDLE, start and in_valid during REPORT
    in_valid = 1'b1; xs3_in = 4'd7;
    tick();
    check_eq("hs_idle_bvalid", 32'(bcd_valid), 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) vec[i] = 4'(12 - i);
    run_window("hs", 1'b1, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
